// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG control block: FSM encoding,
// mode codes and the XNOR-LFSR lock-up values that must never be loaded.
package prng_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    STEP,
    SETTLE,
    DONE
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_FREE = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_REQ  = 2'b11;

  localparam logic [15:0] LOCK16 = 16'hFFFF;
  localparam logic [7:0]  LOCK8  = 8'hFF;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/prng_sequencer_if.sv
// Control/datapath/consumer signal bundle of the PRNG sequencer.
// The master side drives the controls and rnd_byte; the slave is the sequencer.
interface prng_sequencer_if;
  import prng_pkg::*;

  logic        ena;
  logic [1:0]  mode;
  logic        step;
  logic        seed_load;
  logic [15:0] seed;
  logic [7:0]  rnd_byte;
  logic [1:0]  req;
  logic        lfsr16_step;
  logic        lfsr8_step;
  logic        lfsr_load;
  logic [15:0] lfsr_seed16;
  logic [7:0]  lfsr_seed8;
  logic [1:0]  gnt;
  logic        valid;
  logic [7:0]  data;
  state_t      fsm_state;

  // Handshake: req is a level held by each consumer; the sequencer answers with
  // a one-cycle one-hot gnt together with valid, and data is stable while valid
  // is high. A grant may still arrive after req drops; a seed_load abort drops it.
  modport master (
    output ena, mode, step, seed_load, seed, rnd_byte, req,
    input  lfsr16_step, lfsr8_step, lfsr_load, lfsr_seed16, lfsr_seed8,
           gnt, valid, data, fsm_state
  );

  modport slave (
    input  ena, mode, step, seed_load, seed, rnd_byte, req,
    output lfsr16_step, lfsr8_step, lfsr_load, lfsr_seed16, lfsr_seed8,
           gnt, valid, data, fsm_state
  );

endinterface

// File: rtl/prng_tick_gen.sv
// Free-run tick source: counts DATA_DIV cycles while run is high and holds
// at most one pending tick until the sequencer acknowledges it.
module prng_tick_gen #(
  parameter int                   DIV_WIDTH = 24,
  parameter logic [DIV_WIDTH-1:0] DATA_DIV  = DIV_WIDTH'(10_000_000)
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic ack,
  output logic tick_pending
);

  localparam logic [DIV_WIDTH-1:0] TERM = DATA_DIV - DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt;
  logic                 terminal;

  assign terminal = run && (cnt == TERM);

  // Dropping run is the soft clear; a new terminal count wins over a same-cycle ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      tick_pending <= 1'b0;
    end else if (!run) begin
      cnt          <= '0;
      tick_pending <= 1'b0;
    end else begin
      cnt <= terminal ? '0 : cnt + DIV_WIDTH'(1);
      if (terminal)
        tick_pending <= 1'b1;
      else if (ack)
        tick_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/prng_sequencer.sv
// PRNG control block: turns seed loads, free-run ticks, step edges and consumer
// requests into single-cycle LFSR enables and a registered, granted random byte.
module prng_sequencer
  import prng_pkg::*;
#(
  parameter int                   DIV_WIDTH = 24,
  parameter logic [DIV_WIDTH-1:0] DATA_DIV  = DIV_WIDTH'(10_000_000),
  parameter int                   CTRL_DIV  = 8
) (
  input  logic             clk,
  input  logic             reset,
  prng_sequencer_if.slave  bus
);

  localparam int            CW        = (CTRL_DIV > 1) ? $clog2(CTRL_DIV) : 1;
  localparam logic [CW-1:0] CTRL_LAST = CW'(CTRL_DIV - 1);

  state_t        state, state_n;
  logic [1:0]    mode_q;
  logic          step_q;
  logic [CW-1:0] ctrl_cnt;
  logic          win, win_q, txn_req, last_served;
  logic          tick_pending, run, ack, accept, in_idle, mode_chg;
  logic          trig_tick, trig_edge, trig_req;
  logic          l16_q, l8_q, load_q, valid_q;
  logic [15:0]   seed16_q;
  logic [7:0]    seed8_q, data_q;
  logic [1:0]    gnt_q;

  assign in_idle  = (state == IDLE);
  assign mode_chg = in_idle && (bus.mode != mode_q);
  assign run      = bus.ena && (mode_q == MODE_FREE) && !mode_chg;
  assign accept   = bus.ena && !bus.seed_load && (trig_tick || trig_edge || trig_req);
  assign ack      = bus.ena && !bus.seed_load && trig_tick;

  prng_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH),
    .DATA_DIV  (DATA_DIV)
  ) u_tick (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .ack          (ack),
    .tick_pending (tick_pending)
  );

  // The live mode input selects the trigger; a stale tick needs the latched mode too.
  always_comb begin
    trig_tick = 1'b0;
    trig_edge = 1'b0;
    trig_req  = 1'b0;
    if (in_idle) begin
      case (bus.mode)
        MODE_HOLD: ;
        MODE_FREE: trig_tick = tick_pending && (mode_q == MODE_FREE);
        MODE_STEP: trig_edge = bus.step && !step_q;
        MODE_REQ:  trig_req  = |bus.req;
        default:   ;
      endcase
    end
  end

  always_comb begin
    case (bus.req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ~last_served;
    endcase
  end

  always_comb begin
    state_n = state;
    if (!bus.ena)
      state_n = IDLE;
    else if (bus.seed_load)
      state_n = SEED;
    else begin
      case (state)
        IDLE:    if (accept) state_n = STEP;
        SEED:    state_n = IDLE;
        STEP:    state_n = SETTLE;
        SETTLE:  state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= MODE_HOLD;
      step_q      <= 1'b0;
      ctrl_cnt    <= '0;
      win_q       <= 1'b0;
      txn_req     <= 1'b0;
      last_served <= 1'b1;
      l16_q       <= 1'b0;
      l8_q        <= 1'b0;
      load_q      <= 1'b0;
      valid_q     <= 1'b0;
      gnt_q       <= 2'b00;
      seed16_q    <= '0;
      seed8_q     <= '0;
      data_q      <= '0;
    end else begin
      state   <= state_n;
      step_q  <= bus.step;
      l16_q   <= (state_n == STEP);
      l8_q    <= accept && (ctrl_cnt == CTRL_LAST);
      load_q  <= (state_n == SEED);
      valid_q <= (state_n == DONE);
      gnt_q   <= ((state_n == DONE) && txn_req) ? onehot2(win_q) : 2'b00;
      if (!bus.ena)
        ctrl_cnt <= '0;
      else if (accept)
        ctrl_cnt <= (ctrl_cnt == CTRL_LAST) ? '0 : ctrl_cnt + CW'(1);
      if (bus.ena && in_idle)
        mode_q <= bus.mode;
      if (accept) begin
        txn_req <= trig_req;
        win_q   <= win;
        if (trig_req)
          last_served <= win;
      end
      if (state_n == SEED) begin
        seed16_q <= (bus.seed == LOCK16) ? 16'h0000 : bus.seed;
        seed8_q  <= (bus.seed[7:0] == LOCK8) ? 8'h00 : bus.seed[7:0];
      end
      // Only a transaction that actually reaches DONE updates the byte.
      if ((state == SETTLE) && (state_n == DONE))
        data_q <= bus.rnd_byte;
    end
  end

  assign bus.lfsr16_step = l16_q;
  assign bus.lfsr8_step  = l8_q;
  assign bus.lfsr_load   = load_q;
  assign bus.lfsr_seed16 = seed16_q;
  assign bus.lfsr_seed8  = seed8_q;
  assign bus.gnt         = gnt_q;
  assign bus.valid       = valid_q;
  assign bus.data        = data_q;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_prng_sequencer.sv
// Directed bench for prng_sequencer with DATA_DIV=4 and CTRL_DIV=2; every
// expected value is hand-derived, the control-LFSR cadence from a small counter.
module tb_prng_sequencer;
  import prng_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   m_cnt = 0;
  int   n_step, n_valid;
  logic exp_l8;

  prng_sequencer_if bus ();

  prng_sequencer #(
    .DIV_WIDTH (24),
    .DATA_DIV  (24'd4),
    .CTRL_DIV  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control-LFSR step is due when the data-step count is CTRL_DIV-1 = 1.
  task automatic model_step();
    exp_l8 = (m_cnt == 1);
    m_cnt  = exp_l8 ? 0 : m_cnt + 1;
  endtask

  function automatic logic [63:0] all_out();
    return {26'd0, bus.lfsr16_step, bus.lfsr8_step, bus.lfsr_load, bus.lfsr_seed16,
            bus.lfsr_seed8, bus.gnt, bus.valid, bus.data};
  endfunction

  initial begin
    bus.ena       = 1'b1;
    bus.mode      = MODE_REQ;
    bus.step      = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed      = 16'h0000;
    bus.rnd_byte  = 8'h3C;
    bus.req       = 2'b11;

    // Reset held with requests pending
    cyc();
    cyc();
    check("reset_outputs", all_out(), 64'd0);
    check("reset_state", 64'(bus.fsm_state), 64'(IDLE));
    reset = 1'b0;

    // Both requesting: requester 0 first, then requester 1
    cyc();
    model_step();
    check("req0_step", 64'(bus.lfsr16_step), 64'd1);
    check("req0_l8", 64'(bus.lfsr8_step), 64'(exp_l8));
    cyc();
    check("req0_settle_valid", 64'(bus.valid), 64'd0);
    cyc();
    check("req0_valid", 64'(bus.valid), 64'd1);
    check("req0_gnt", 64'(bus.gnt), 64'h1);
    check("req0_data", 64'(bus.data), 64'h3C);
    cyc();
    check("req0_gnt_drop", 64'(bus.gnt), 64'h0);
    cyc();
    model_step();
    check("req1_step", 64'(bus.lfsr16_step), 64'd1);
    check("req1_l8", 64'(bus.lfsr8_step), 64'(exp_l8));
    cyc();
    cyc();
    check("req1_gnt", 64'(bus.gnt), 64'h2);
    check("req1_valid", 64'(bus.valid), 64'd1);
    bus.req  = 2'b00;
    bus.mode = MODE_HOLD;
    cyc();

    // Seed loads, including the lock-up value
    bus.seed      = 16'hFFFF;
    bus.seed_load = 1'b1;
    cyc();
    bus.seed_load = 1'b0;
    check("seed_ff_load", 64'(bus.lfsr_load), 64'd1);
    check("seed_ff_s16", 64'(bus.lfsr_seed16), 64'h0000);
    check("seed_ff_s8", 64'(bus.lfsr_seed8), 64'h00);
    cyc();
    check("seed_load_pulse", 64'(bus.lfsr_load), 64'd0);
    bus.seed      = 16'h1234;
    bus.seed_load = 1'b1;
    cyc();
    bus.seed_load = 1'b0;
    check("seed_1234_load", 64'(bus.lfsr_load), 64'd1);
    check("seed_1234_s16", 64'(bus.lfsr_seed16), 64'h1234);
    check("seed_1234_s8", 64'(bus.lfsr_seed8), 64'h34);
    cyc();

    // Hold mode ignores a step edge
    bus.step = 1'b1;
    cyc();
    check("hold_no_step", 64'(bus.lfsr16_step), 64'd0);
    check("hold_idle", 64'(bus.fsm_state), 64'(IDLE));
    bus.step = 1'b0;
    cyc();

    // Free-run: step every 4 cycles, control step every second data step
    bus.rnd_byte = 8'hA5;
    bus.mode     = MODE_FREE;
    for (int i = 0; i < 20 && bus.lfsr16_step !== 1'b1; i++) cyc();
    check("free_first_step", 64'(bus.lfsr16_step), 64'd1);
    for (int k = 0; k < 4; k++) begin
      model_step();
      check("free_step", 64'(bus.lfsr16_step), 64'd1);
      check("free_l8", 64'(bus.lfsr8_step), 64'(exp_l8));
      cyc();
      check("free_gap", 64'(bus.lfsr16_step), 64'd0);
      cyc();
      check("free_valid", 64'(bus.valid), 64'd1);
      check("free_data", 64'(bus.data), 64'hA5);
      if (k == 3) bus.mode = MODE_HOLD;
      cyc();
      cyc();
    end
    check("free_stop", 64'(bus.lfsr16_step), 64'd0);
    check("free_stop_idle", 64'(bus.fsm_state), 64'(IDLE));

    // Single-step: step held high for 10 cycles yields one transaction
    bus.mode = MODE_STEP;
    bus.step = 1'b1;
    n_step   = 0;
    n_valid  = 0;
    for (int i = 0; i < 13; i++) begin
      if (i == 10) bus.step = 1'b0;
      cyc();
      n_step  += int'(bus.lfsr16_step);
      n_valid += int'(bus.valid);
    end
    model_step();
    check("single_step_count", 64'(n_step), 64'd1);
    check("single_valid_count", 64'(n_valid), 64'd1);

    // seed_load in SETTLE aborts the request transaction
    bus.mode     = MODE_REQ;
    bus.req      = 2'b01;
    bus.rnd_byte = 8'h77;
    cyc();
    model_step();
    check("abort_step", 64'(bus.lfsr16_step), 64'd1);
    check("abort_l8", 64'(bus.lfsr8_step), 64'(exp_l8));
    cyc();
    bus.seed      = 16'h00FF;
    bus.seed_load = 1'b1;
    cyc();
    bus.seed_load = 1'b0;
    bus.req       = 2'b00;
    check("abort_load", 64'(bus.lfsr_load), 64'd1);
    check("abort_no_valid", 64'(bus.valid), 64'd0);
    check("abort_no_gnt", 64'(bus.gnt), 64'h0);
    check("abort_data", 64'(bus.data), 64'hA5);
    check("abort_s16", 64'(bus.lfsr_seed16), 64'h00FF);
    check("abort_s8", 64'(bus.lfsr_seed8), 64'h00);
    cyc();
    check("abort_after_valid", 64'(bus.valid), 64'd0);
    check("abort_after_gnt", 64'(bus.gnt), 64'h0);

    // ena dropped in STEP: back to IDLE, strobes clear, control counter clears
    bus.req = 2'b10;
    cyc();
    model_step();
    check("ena_step", 64'(bus.lfsr16_step), 64'd1);
    check("ena_l8", 64'(bus.lfsr8_step), 64'(exp_l8));
    bus.ena = 1'b0;
    cyc();
    m_cnt = 0;
    check("ena_idle", 64'(bus.fsm_state), 64'(IDLE));
    check("ena_strobes", 64'({bus.lfsr16_step, bus.lfsr8_step, bus.lfsr_load, bus.valid, bus.gnt}), 64'h0);
    check("ena_data_kept", 64'(bus.data), 64'hA5);
    bus.ena = 1'b1;
    cyc();
    model_step();
    check("ena_re_step", 64'(bus.lfsr16_step), 64'd1);
    check("ena_re_l8", 64'(bus.lfsr8_step), 64'(exp_l8));
    cyc();
    cyc();
    check("ena_re_gnt", 64'(bus.gnt), 64'h2);
    check("ena_re_valid", 64'(bus.valid), 64'd1);
    check("ena_re_data", 64'(bus.data), 64'h77);

    // Asynchronous reset in the middle of a transaction
    bus.req = 2'b01;
    cyc();
    cyc();
    check("mid_step", 64'(bus.lfsr16_step), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_outputs", all_out(), 64'd0);
    check("mid_reset_state", 64'(bus.fsm_state), 64'(IDLE));
    cyc();
    reset = 1'b0;
    bus.req = 2'b00;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prng_sequencer.md
Name: prng_sequencer

Overview:
Control block for the PRNG datapath (16-bit XNOR LFSR data source, 8-bit XNOR LFSR mux control, 16-to-8 mux). It replaces the ripple-generated divided clocks with single-cycle step enables on one clock. It sequences seed loading, free-run, single-step and request-driven stepping. It also arbitrates the random byte between two consumers so each grant carries a freshly stepped value.

Parameters:
DIV_WIDTH, 24, width of the free-run tick counter
DATA_DIV, 24'd10_000_000, clk cycles between data-LFSR steps in free-run; must be at least 4
CTRL_DIV, 8, data steps per control-LFSR step; must be at least 1

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
ena  input  1  block enable; low behaves as a synchronous soft clear
mode  input  2  2'b00 hold, 2'b01 free-run, 2'b10 single-step, 2'b11 request-driven
step  input  1  single-step trigger; its rising edge is detected internally
seed_load  input  1  one-cycle pulse that loads seed
seed  input  16  seed value
rnd_byte  input  8  mux output from the datapath
req  input  2  consumer requests; level-sensitive
lfsr16_step  output  1  one-cycle enable for the data LFSR
lfsr8_step  output  1  one-cycle enable for the control LFSR
lfsr_load  output  1  one-cycle parallel-load strobe for both LFSRs
lfsr_seed16  output  16  load value for the data LFSR
lfsr_seed8  output  8  load value for the control LFSR
gnt  output  2  one-hot grant, one cycle
valid  output  1  data qualifier, one cycle
data  output  8  captured random byte

Behaviour:
- Reset value of every output is 0. State is IDLE, counters are 0, and last_served is 1, so requester 0 wins first.
- FSM states: IDLE, SEED, STEP, SETTLE, DONE. All outputs are registered and decoded from state.
- IDLE exits on the first trigger found, in this priority: seed_load, then pending tick (mode 01), then step rising edge (mode 10), then any req bit (mode 11). With no trigger, the FSM stays in IDLE.
- SEED: lfsr_load=1 for one cycle, then the FSM returns to IDLE.
  - lfsr_seed16 = seed, except 16'hFFFF is replaced by 16'h0000 (XNOR lock-up state).
  - lfsr_seed8 = seed[7:0], except 8'hFF is replaced by 8'h00.
- STEP: lfsr16_step=1 for one cycle.
  - lfsr8_step=1 in the same cycle when the data-step counter equals CTRL_DIV-1; the counter then wraps to 0, otherwise it increments.
- SETTLE: one wait cycle, so the mux output reflects the new LFSR states. At the end of this cycle, data is loaded from rnd_byte.
- DONE: valid=1 for one cycle.
  - In mode 11, gnt is also set, one-hot to the chosen requester.
  - The FSM then returns to IDLE.
- Latency: trigger accepted at edge k gives lfsr16_step high in cycle k+1, and valid/gnt high in cycle k+3. One transaction takes 4 cycles.
- Arbitration (mode 11), evaluated in IDLE:
  - If only one req bit is set, that requester wins.
  - If both are set, the requester other than last_served wins.
  - The winner is latched and last_served is updated on entry to STEP.
  - A grant is delivered even if req drops mid-transaction.
  - req is ignored outside mode 11.
- Free-run tick:
  - The counter runs every cycle while ena=1 and mode=01, from 0 to DATA_DIV-1.
  - At terminal count it sets a pending flag; the flag is cleared when IDLE accepts the tick.
  - A terminal count while the flag is already set is dropped; no queueing beyond one.
  - Steady-state step period is exactly DATA_DIV cycles.
- Step edge detection: step is registered once; a rising edge is detected only while in IDLE. Edges seen in other states are ignored.
- Mode changes are sampled only in IDLE. A mode change clears the tick counter and the pending flag.
- seed_load outside IDLE aborts the current transaction:
  - The next state is SEED.
  - No valid or gnt is produced.
  - data keeps its old value.
- ena=0, on the next edge:
  - The FSM goes to IDLE and all counters, pending flags and strobes clear.
  - data and last_served keep their values.
- mode 00: the FSM stays in IDLE; seed_load is still honoured.
- reset mid-operation: all state clears immediately (asynchronous), with no partial strobes.

Decomposition:
- Package prng_pkg holds:
  - the state encoding enum;
  - the mode constants MODE_HOLD, MODE_FREE, MODE_STEP, MODE_REQ;
  - the lock-up constants LOCK16=16'hFFFF and LOCK8=8'hFF.
- Sub-module prng_tick_gen contains the DATA_DIV counter and pending flag, with inputs clk, reset, run, ack and output tick_pending.

Test Plan:
- Reset with req=2'b11 and mode=11 held → all outputs 0 while reset is high. After release: lfsr16_step in cycle 1, gnt=2'b01 with valid in cycle 3, then the next grant is 2'b10.
- seed_load with seed=16'hFFFF → lfsr_load one cycle, lfsr_seed16=16'h0000, lfsr_seed8=8'h00. With seed=16'h1234 → lfsr_seed16=16'h1234, lfsr_seed8=8'h34.
- mode=01, DATA_DIV=4, CTRL_DIV=2 → lfsr16_step every 4 cycles; lfsr8_step on every second lfsr16_step. Drive rnd_byte=8'hA5 → data=8'hA5 with valid 2 cycles after each step.
- mode=10, step held high for 10 cycles → exactly one lfsr16_step and one valid.
- seed_load in the SETTLE cycle of a req transaction → no gnt or valid, lfsr_load follows, and data is unchanged.
- ena dropped in the STEP cycle → next cycle is IDLE with all strobes 0. ena re-raised with req=2'b10 → gnt=2'b10 after 3 cycles.
